comp_serie_n: RTL and testbench

- Parametrised, sequential successor of the single-bit magnitude comparator.
- Compares two WIDTH-bit operands bit-serially, MSB first, one bit per clock, with early termination on the first differing bit.
- Supports unsigned and two's-complement signed mode, selected per operation.
- Uses a start/busy/done handshake and also reports how many bits were examined. It sits beside the ALU exercises as a reusable compare unit.

---
 rtl/comp_serie_n.sv | 131 +++++++++++++
 tb/tb_comp_serie_n.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/comp_serie_n.sv
// Bit-serial MSB-first magnitude comparator with start/busy/done handshake,
// unsigned or two's-complement signed mode, and a count of examined bits.
module comp_serie_n #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic [WIDTH-1:0]               a,
  input  logic [WIDTH-1:0]               b,
  input  logic                           signo,
  output logic                           busy,
  output logic                           done,
  output logic                           mayor,
  output logic                           igual,
  output logic                           menor,
  output logic [$clog2(WIDTH+1)-1:0]     ciclos
);

  localparam int unsigned IW = $clog2(WIDTH);
  localparam int unsigned CW = $clog2(WIDTH + 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] COMP = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic             signo_q, signo_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             mayor_q, mayor_d;
  logic             igual_q, igual_d;
  logic             menor_q, menor_d;
  logic [CW-1:0]    ciclos_q, ciclos_d;

  logic ai, bi, sign_pos;

  assign ai       = a_sh_q[WIDTH-1];
  assign bi       = b_sh_q[WIDTH-1];
  assign sign_pos = signo_q && (idx_q == IW'(WIDTH - 1));

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    signo_d  = signo_q;
    idx_d    = idx_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    mayor_d  = mayor_q;
    igual_d  = igual_q;
    menor_d  = menor_q;
    ciclos_d = ciclos_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d   = a;
          b_sh_d   = b;
          signo_d  = signo;
          idx_d    = IW'(WIDTH - 1);
          mayor_d  = 1'b0;
          igual_d  = 1'b0;
          menor_d  = 1'b0;
          ciclos_d = '0;
          busy_d   = 1'b1;
          state_d  = COMP;
        end
      end
      COMP: begin
        ciclos_d = ciclos_q + CW'(1);
        if (ai != bi) begin
          // At the sign position a set bit means a negative A, so the sense inverts.
          if (ai ^ sign_pos) mayor_d = 1'b1;
          else               menor_d = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (idx_q == '0) begin
          igual_d = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          a_sh_d = {a_sh_q[WIDTH-2:0], 1'b0};
          b_sh_d = {b_sh_q[WIDTH-2:0], 1'b0};
          idx_d  = idx_q - IW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      signo_q  <= 1'b0;
      idx_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      mayor_q  <= 1'b0;
      igual_q  <= 1'b0;
      menor_q  <= 1'b0;
      ciclos_q <= '0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      signo_q  <= signo_d;
      idx_q    <= idx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      mayor_q  <= mayor_d;
      igual_q  <= igual_d;
      menor_q  <= menor_d;
      ciclos_q <= ciclos_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign mayor  = mayor_q;
  assign igual  = igual_q;
  assign menor  = menor_q;
  assign ciclos = ciclos_q;

endmodule

// File: tb/tb_comp_serie_n.sv
// Directed-vector bench for comp_serie_n: WIDTH=8 table and handshake corners,
// plus an exhaustive WIDTH=4 sweep against a reference magnitude compare.
module tb_comp_serie_n;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start8 = 1'b0, signo8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, mayor8, igual8, menor8;
  logic [3:0] ciclos8;

  logic       start4 = 1'b0, signo4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       busy4, done4, mayor4, igual4, menor4;
  logic [2:0] ciclos4;

  comp_serie_n #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .signo(signo8),
    .busy(busy8), .done(done8), .mayor(mayor8), .igual(igual8), .menor(menor8),
    .ciclos(ciclos8)
  );

  comp_serie_n #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .signo(signo4),
    .busy(busy4), .done(done4), .mayor(mayor4), .igual(igual4), .menor(menor4),
    .ciclos(ciclos4)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       s;
    logic [2:0] flags;  // {mayor, igual, menor}
    logic [3:0] cic;
  } vec_t;

  vec_t vecs[10];

  task automatic wait_done8(output int edges);
    edges = 0;
    while (!done8 && edges < 40) begin
      @(negedge clk);
      edges++;
    end
    check("done8_seen", done8, 1);
  endtask

  // Issue a start at the next negedge; returns at the negedge where done is high.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic s, output int edges);
    @(negedge clk);
    a8 = a; b8 = b; signo8 = s; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    wait_done8(edges);
  endtask

  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic s, output int edges);
    @(negedge clk);
    a4 = a; b4 = b; signo4 = s; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    edges = 0;
    while (!done4 && edges < 20) begin
      @(negedge clk);
      edges++;
    end
  endtask

  initial begin
    int edges;
    logic [2:0] exp_flags;
    logic [2:0] exp_cic;
    logic [3:0] x;

    vecs[0] = '{8'h5A, 8'h5A, 1'b0, 3'b010, 4'd8};
    vecs[1] = '{8'h80, 8'h7F, 1'b0, 3'b100, 4'd1};
    vecs[2] = '{8'h80, 8'h7F, 1'b1, 3'b001, 4'd1};
    vecs[3] = '{8'h13, 8'h12, 1'b0, 3'b100, 4'd8};
    vecs[4] = '{8'hFE, 8'hFF, 1'b1, 3'b001, 4'd8};
    vecs[5] = '{8'h00, 8'h01, 1'b0, 3'b001, 4'd8};
    vecs[6] = '{8'h7F, 8'h80, 1'b1, 3'b100, 4'd1};
    vecs[7] = '{8'h40, 8'h20, 1'b1, 3'b100, 4'd2};
    vecs[8] = '{8'h20, 8'h40, 1'b0, 3'b001, 4'd2};
    vecs[9] = '{8'h81, 8'h81, 1'b1, 3'b010, 4'd8};

    // Reset state
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_state", {busy8, done8, mayor8, igual8, menor8, ciclos8}, '0);
    rst_n = 1'b1;

    // Table-driven WIDTH=8 vectors
    foreach (vecs[i]) begin
      op8(vecs[i].a, vecs[i].b, vecs[i].s, edges);
      check($sformatf("v%0d_flags", i), {mayor8, igual8, menor8}, vecs[i].flags);
      check($sformatf("v%0d_ciclos", i), ciclos8, vecs[i].cic);
      check($sformatf("v%0d_edges", i), edges, vecs[i].cic);
      @(negedge clk);
      check($sformatf("v%0d_done_pulse", i), {done8, busy8}, 2'b00);
      check($sformatf("v%0d_hold", i), {mayor8, igual8, menor8, ciclos8},
            {vecs[i].flags, vecs[i].cic});
    end

    // Busy during a comparison; start while busy is ignored
    @(negedge clk);
    a8 = 8'h00; b8 = 8'h01; signo8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    check("busy_after_start", {busy8, done8}, 2'b10);
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'h00; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    wait_done8(edges);
    check("ignored_flags", {mayor8, igual8, menor8}, 3'b001);
    check("ignored_ciclos", ciclos8, 8);

    // Back-to-back: start during the done cycle is accepted
    a8 = 8'h01; b8 = 8'h02; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    check("b2b_busy", {busy8, done8}, 2'b10);
    check("b2b_cleared", {mayor8, igual8, menor8, ciclos8}, '0);
    a8 = 8'hAA; b8 = 8'h55;
    wait_done8(edges);
    check("b2b_result", {mayor8, igual8, menor8, ciclos8}, {3'b001, 4'd7});

    // Reset at the 4th compare edge discards the partial result
    @(negedge clk);
    a8 = 8'h01; b8 = 8'h00; signo8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midreset_state", {busy8, done8, mayor8, igual8, menor8, ciclos8}, '0);
    op8(8'h01, 8'h00, 1'b0, edges);
    check("after_reset_result", {mayor8, igual8, menor8, ciclos8}, {3'b100, 4'd8});

    // Exhaustive WIDTH=4 sweep
    for (int s = 0; s < 2; s++) begin
      for (int ia = 0; ia < 16; ia++) begin
        for (int ib = 0; ib < 16; ib++) begin
          if (s == 1) begin
            if ($signed(4'(ia)) > $signed(4'(ib)))      exp_flags = 3'b100;
            else if ($signed(4'(ia)) < $signed(4'(ib))) exp_flags = 3'b001;
            else                                        exp_flags = 3'b010;
          end else begin
            if (ia > ib)      exp_flags = 3'b100;
            else if (ia < ib) exp_flags = 3'b001;
            else              exp_flags = 3'b010;
          end
          x = 4'(ia ^ ib);
          if (x[3])      exp_cic = 3'd1;
          else if (x[2]) exp_cic = 3'd2;
          else if (x[1]) exp_cic = 3'd3;
          else           exp_cic = 3'd4;
          op4(4'(ia), 4'(ib), 1'(s), edges);
          check($sformatf("w4 s=%0d a=%0h b=%0h", s, ia, ib),
                {done4, mayor4, igual4, menor4, ciclos4}, {1'b1, exp_flags, exp_cic});
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
